// File: rtl/ram_rd_stream.sv
// Read sequencer for the nn buffer RAM: issues a burst of consecutive reads and
// replays the returned words as a valid/ready stream with a last flag.
module ram_rd_stream #(
   parameter int BW     = 40,
   parameter int AW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   output logic [AW-1:0] adrr_rd,
   input  logic [BW-1:0] data_rd,
   output logic [BW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic          busy,
   output logic          done
);

   localparam int DEPTH = RD_LAT + 2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SLOTS = 1 << CW;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state;
   logic [AW:0]      remaining;
   logic [CW-1:0]    fifo_count;
   logic [CW-1:0]    wr_idx;
   logic [BW-1:0]    q_data [SLOTS];
   logic [SLOTS-1:0] q_last;
   logic [CW:0]      occupancy;
   logic             issue, issue_last, in_flight, cap_vld, cap_last, pop;

   // Issue only when every word already requested is guaranteed a FIFO slot.
   assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, in_flight};
   assign issue      = (state == RUN) && (occupancy < DEPTH_W);
   assign issue_last = issue && (remaining == (AW + 1)'(1));
   assign pop        = m_valid && m_ready;
   assign wr_idx     = fifo_count - CW'(pop);

   assign m_valid = (fifo_count != '0);
   assign m_data  = q_data[0];
   assign m_last  = q_last[0];

   generate
      if (RD_LAT == 0) begin : g_lat0
         assign in_flight = 1'b0;
         assign cap_vld   = issue;
         assign cap_last  = issue_last;
      end else begin : g_lat1
         logic fl_vld, fl_last;

         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
               fl_vld  <= 1'b0;
               fl_last <= 1'b0;
            end else begin
               fl_vld  <= issue;
               fl_last <= issue_last;
            end
         end

         assign in_flight = fl_vld;
         assign cap_vld   = fl_vld;
         assign cap_last  = fl_last;
      end
   endgenerate

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         adrr_rd   <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               if (start) begin
                  adrr_rd   <= base_addr;
                  remaining <= len;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  adrr_rd   <= adrr_rd + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (issue_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Shift FIFO: slot 0 is always the head, so the stream outputs come straight from a register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         fifo_count <= '0;
         q_last     <= '0;
         for (int i = 0; i < SLOTS; i++) q_data[i] <= '0;
      end else begin
         if (pop) begin
            for (int i = 0; i < SLOTS - 1; i++) q_data[i] <= q_data[i+1];
            q_last <= {1'b0, q_last[SLOTS-1:1]};
         end
         if (cap_vld) begin
            q_data[wr_idx] <= data_rd;
            q_last[wr_idx] <= cap_last;
         end
         fifo_count <= fifo_count + CW'(cap_vld) - CW'(pop);
      end
   end

endmodule
